// File: rtl/motor_cmd_rx.sv
// SPI-style motor command receiver: oversamples sck/sdi/load, commits whole 16-bit frames
// to clamped sign/magnitude registers, and zeroes the motors if valid frames stop arriving.
module motor_cmd_rx #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 600000,
  parameter logic [6:0]  MAX_MAG        = 7'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       load,
  output logic       sdo,
  output logic       motor1_sign,
  output logic [6:0] motor1_mag,
  output logic       motor2_sign,
  output logic [6:0] motor2_mag,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ERR} state_t;

  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
  } motor_t;

  // sck/load carry one extra flop past the synchroniser for edge detection
  logic [SYNC_STAGES:0]   sck_sync_q, load_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;

  state_t          state_q;
  logic [15:0]     shift_q;
  logic [4:0]      bitcnt_q;
  logic [15:0]     rb_q;
  logic [15:0]     last_q;
  logic            sdo_q;
  motor_t          m1_q, m2_q;
  logic            cmd_valid_q, frame_err_q, timeout_q;
  logic [WD_W-1:0] wd_q;

  logic       sck_rise, sck_fall, load_rise, load_fall, sdi_s;
  logic [4:0] cnt_inc, cnt_now;
  logic       wd_expire;
  motor_t     m1_d, m2_d;

  function automatic logic [6:0] clamp(input logic [6:0] m);
    return (m > MAX_MAG) ? MAX_MAG : m;
  endfunction

  assign sck_rise  =  sck_sync_q[SYNC_STAGES-1]  & ~sck_sync_q[SYNC_STAGES];
  assign sck_fall  = ~sck_sync_q[SYNC_STAGES-1]  &  sck_sync_q[SYNC_STAGES];
  assign load_rise =  load_sync_q[SYNC_STAGES-1] & ~load_sync_q[SYNC_STAGES];
  assign load_fall = ~load_sync_q[SYNC_STAGES-1] &  load_sync_q[SYNC_STAGES];
  assign sdi_s     =  sdi_sync_q[SYNC_STAGES-1];

  // A sck edge coincident with load falling is counted before the length check
  assign cnt_inc   = (bitcnt_q == 5'd17) ? 5'd17 : bitcnt_q + 5'd1;
  assign cnt_now   = sck_rise ? cnt_inc : bitcnt_q;
  assign wd_expire = (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

  assign m1_d = '{sign: shift_q[15], mag: clamp(shift_q[14:8])};
  assign m2_d = '{sign: shift_q[7],  mag: clamp(shift_q[6:0])};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q  <= '0;
      load_sync_q <= '0;
      sdi_sync_q  <= '0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      rb_q        <= '0;
      last_q      <= '0;
      sdo_q       <= 1'b0;
      m1_q        <= '0;
      m2_q        <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b1;
      wd_q        <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-1:0], sck};
      load_sync_q <= {load_sync_q[SYNC_STAGES-1:0], load};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (wd_q != WD_W'(TIMEOUT_CYCLES)) wd_q <= wd_q + 1'b1;
      if (wd_expire) begin
        m1_q      <= '0;
        m2_q      <= '0;
        timeout_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          sdo_q <= 1'b0;
          if (load_rise) begin
            state_q  <= SHIFT;
            bitcnt_q <= '0;
            sdo_q    <= last_q[15];
            rb_q     <= {last_q[14:0], 1'b0};
          end
        end
        SHIFT: begin
          if (load_rise) begin
            bitcnt_q <= '0;
            sdo_q    <= last_q[15];
            rb_q     <= {last_q[14:0], 1'b0};
          end else begin
            if (sck_rise) begin
              shift_q  <= {shift_q[14:0], sdi_s};
              bitcnt_q <= cnt_inc;
            end
            if (sck_fall) begin
              sdo_q <= rb_q[15];
              rb_q  <= {rb_q[14:0], 1'b0};
            end
            if (load_fall) begin
              state_q <= (cnt_now == 5'd16) ? COMMIT : ERR;
              sdo_q   <= 1'b0;
            end
          end
        end
        COMMIT: begin
          // Overrides any same-cycle watchdog expiry above
          m1_q        <= m1_d;
          m2_q        <= m2_d;
          last_q      <= {m1_d, m2_d};
          cmd_valid_q <= 1'b1;
          timeout_q   <= 1'b0;
          wd_q        <= '0;
          state_q     <= IDLE;
        end
        ERR: begin
          frame_err_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdo         = sdo_q;
  assign motor1_sign = m1_q.sign;
  assign motor1_mag  = m1_q.mag;
  assign motor2_sign = m2_q.sign;
  assign motor2_mag  = m2_q.mag;
  assign cmd_valid   = cmd_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_motor_cmd_rx.sv
// Directed bench for motor_cmd_rx: drives SPI frames at clk/8 and checks commits,
// errors, clamping, watchdog expiry timing, sdo readback and mid-frame reset.
module tb_motor_cmd_rx;

  localparam int TO   = 2000;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset, sck, sdi, load;
  logic       sdo, motor1_sign, motor2_sign, cmd_valid, frame_err, timeout;
  logic [6:0] motor1_mag, motor2_mag;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_err   = 0;

  motor_cmd_rx #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TO),
    .MAX_MAG       (7'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .load       (load),
    .sdo        (sdo),
    .motor1_sign(motor1_sign),
    .motor1_mag (motor1_mag),
    .motor2_sign(motor2_sign),
    .motor2_mag (motor2_mag),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid) n_valid <= n_valid + 1;
    if (frame_err) n_err   <= n_err + 1;
  end

  function automatic logic [15:0] out_word();
    return {motor1_sign, motor1_mag, motor2_sign, motor2_mag};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [31:0] data, input int nbits, output logic [31:0] rb);
    rb = '0;
    for (int i = 0; i < nbits; i++) begin
      sdi = data[nbits-1-i];
      repeat (HALF) @(negedge clk);
      rb  = {rb[30:0], sdo};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] data, input int nbits, output logic [31:0] rb);
    load = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_bits(data, nbits, rb);
    repeat (HALF) @(negedge clk);
    load = 1'b0;
  endtask

  // Result pulse lands on the 4th clk edge after load falls (SYNC_STAGES+2)
  task automatic end_frame(input string tag, input logic [1:0] exp_pulse);
    repeat (3) @(negedge clk);
    chk({tag, "_early"}, {30'd0, cmd_valid, frame_err}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, cmd_valid, frame_err}, {30'd0, exp_pulse});
  endtask

  logic [31:0] rb;
  int          err_snap;

  initial begin
    reset = 1'b0; sck = 1'b0; sdi = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_out",     {16'd0, out_word()}, 32'd0);
    chk("rst_flags",   {28'd0, sdo, cmd_valid, frame_err, timeout}, 32'h1);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    // basic commit
    spi_frame(32'h9932, 16, rb);
    end_frame("t1", 2'b10);
    chk("t1_out",      {16'd0, out_word()}, 32'h9932);
    chk("t1_mag1",     {25'd0, motor1_mag}, 32'd25);
    chk("t1_mag2",     {25'd0, motor2_mag}, 32'd50);
    chk("t1_timeout",  {31'd0, timeout}, 32'd0);

    // short and long frames are discarded
    spi_frame(32'h0ABC, 15, rb);
    end_frame("t2a", 2'b01);
    chk("t2a_out",     {16'd0, out_word()}, 32'h9932);
    spi_frame(32'h1FFFF, 17, rb);
    end_frame("t2b", 2'b01);
    chk("t2b_out",     {16'd0, out_word()}, 32'h9932);
    chk("t2_timeout",  {31'd0, timeout}, 32'd0);

    // stray sck with load low, then a frame needing clamping on both motors
    sdi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (HALF) @(negedge clk); sck = 1'b1;
      repeat (HALF) @(negedge clk); sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_frame(32'h7FFF, 16, rb);
    end_frame("t3", 2'b10);
    chk("t3_out",      {16'd0, out_word()}, 32'h64E4);

    // readback of the previously committed frame
    spi_frame(32'h9932, 16, rb);
    end_frame("t5a", 2'b10);
    spi_frame(32'h5A5A, 16, rb);
    end_frame("t5b", 2'b10);
    chk("t5_readback", {16'd0, rb[15:0]}, 32'h9932);
    chk("t5_out",      {16'd0, out_word()}, 32'h5A5A);

    // watchdog expires exactly TO clk after the commit edge
    repeat (TO - 1) @(negedge clk);
    chk("t4_pre_to",   {31'd0, timeout}, 32'd0);
    chk("t4_pre_out",  {16'd0, out_word()}, 32'h5A5A);
    @(negedge clk);
    chk("t4_to",       {31'd0, timeout}, 32'd1);
    chk("t4_to_out",   {16'd0, out_word()}, 32'd0);
    spi_frame(32'h0123, 15, rb);
    end_frame("t4_err", 2'b01);
    chk("t4_err_to",   {31'd0, timeout}, 32'd1);
    spi_frame(32'h9932, 16, rb);
    end_frame("t4_rest", 2'b10);
    chk("t4_rest_out", {16'd0, out_word()}, 32'h9932);
    chk("t4_rest_to",  {31'd0, timeout}, 32'd0);

    // reset mid-frame after 8 bits
    err_snap = n_err;
    load = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_bits(32'hFF, 8, rb);
    reset = 1'b0; load = 1'b0; sck = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rst_out",  {16'd0, out_word()}, 32'd0);
    chk("t6_rst_to",   {31'd0, timeout}, 32'd1);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    spi_frame(32'h1234, 16, rb);
    end_frame("t6", 2'b10);
    chk("t6_out",      {16'd0, out_word()}, 32'h1234);
    chk("t6_mags",     {18'd0, motor1_mag, motor2_mag}, {18'd0, 7'd18, 7'd52});
    chk("t6_no_err",   n_err, err_snap);
    @(negedge clk);
    chk("pulse_clear", {30'd0, cmd_valid, frame_err}, 32'd0);
    chk("n_valid",     n_valid, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
